ip_write_rx: RTL
================

Name: ip_write_rx

Overview:
- Receiving end of the writeback-stage IP write channel (32-bit data plus IP_write strobe leaving the MEM/WB pipeline register).
- Buffers each IP write in a small FIFO and presents it to the IP-side slave over a valid/ready handshake.
- Raises a stall to the pipeline when the buffer is full, so the core never blocks on a slow IP.

Parameters:
- DATA_W, 32, width of write data.
- DEPTH, 4, FIFO entries; power of two, at least 2.
- LVL_W, 3, width of level output; equals clog2(DEPTH+1).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous reset, active-low; the block is in reset while rst=0.
- wb_data  in  DATA_W  write data from the MEM/WB register.
- wb_ip_write  in  1  write request qualifier; 1 = push wb_data this cycle.
- wb_stall  out  1  1 = FIFO full; the pipeline must hold the MEM/WB register.
- ip_valid  out  1  output word is valid.
- ip_data  out  DATA_W  output word; stable while ip_valid=1 and ip_ready=0.
- ip_ready  in  1  IP-side slave accepts the word.
- fifo_level  out  LVL_W  number of words in the FIFO, excluding the output register.
- overflow  out  1  sticky error: a push was attempted while full.

Behaviour:
- Reset (rst=0, asynchronous): all outputs and state are 0 (wb_stall, ip_valid, ip_data, fifo_level, overflow); the FSM enters IDLE; read and write pointers are 0. Release is synchronous to clk.
- Push: accepted iff wb_ip_write=1 and registered level < DEPTH. The word is written at the write pointer and the pointer increments modulo DEPTH (wraps DEPTH-1 -> 0).
- wb_stall is combinational from the registered level: (level == DEPTH).
- Push while full:
  - The word is dropped and overflow is set.
  - overflow stays set until reset.
  - No pointer change.
  - The push is rejected even if a pop occurs in the same cycle.
- Output FSM, states IDLE and SEND:
  - IDLE: ip_valid=0. If level>0, pop the head into ip_data, set ip_valid=1 and go to SEND.
  - SEND: ip_valid=1 and ip_data is held.
    - ip_ready=1 and level>0: pop the next word into ip_data and stay in SEND (back-to-back, one word per cycle).
    - ip_ready=1 and level=0: ip_valid goes to 0 and the FSM returns to IDLE.
    - ip_ready=0: hold.
- Latency: a push sampled at edge N makes ip_valid=1 after edge N+1, i.e. two cycles from strobe to valid. There is no FIFO bypass.
- Simultaneous push and pop: the level is unchanged; both pointers advance.
- ip_ready while ip_valid=0: ignored.
- Mid-operation reset: the FIFO contents and any pending output word are discarded, with no partial handshake. ip_valid drops immediately, asynchronously.
- Level arithmetic is unsigned LVL_W bits and never exceeds DEPTH.

Decomposition:
- Shared package ip_if_pkg holds:
  - DATA_W default;
  - FSM state encoding (IDLE=1'b0, SEND=1'b1);
  - clog2 function for LVL_W.
- One natural sub-module, ip_wr_fifo: storage array, pointers, level, full and empty. It has synchronous push and pop and an asynchronous active-low reset of the pointers and level.
- The FSM, output register and overflow flag stay in ip_write_rx.

Test Plan:
- Reset: hold rst=0 with wb_ip_write=1 -> ip_valid=0, fifo_level=0, wb_stall=0, overflow=0 throughout.
- Single write: push 0xDEADBEEF at cycle 0 with ip_ready=1 -> ip_valid=1 and ip_data=0xDEADBEEF in cycle 2; ip_valid=0 in cycle 3; fifo_level returns to 0.
- Backpressure and full:
  - With ip_ready=0, push 0x1..0x5 on consecutive cycles.
  - Expect ip_data=0x1 held; after the 5th push, fifo_level=4 and wb_stall=1.
  - A 6th push (0x6) sets overflow=1 and 0x6 is never output.
- Drain order: from the full state, set ip_ready=1 -> outputs 0x1, 0x2, 0x3, 0x4, 0x5 on consecutive cycles; then ip_valid=0 and wb_stall=0.
- Wrap and simultaneous push/pop:
  - Stream 10 words 0xA0..0xA9, one per cycle, with ip_ready=1.
  - Expect fifo_level never >1 after the first pop.
  - Outputs arrive in order across pointer wrap.
- Mid-operation reset: with 3 words queued and ip_valid=1, pulse rst=0 for 1 cycle -> ip_valid=0 immediately, fifo_level=0; the next push of 0x55 is output as the first word.

Source files
------------

// File: rtl/ip_if_pkg.sv
// ip_if_pkg: shared constants for the IP write channel.
//   DATA_W     default write-data width
//   IDLE/SEND  output FSM state encoding
//   clog2      ceil(log2(v)), used to size pointers and the level output
package ip_if_pkg;
  localparam int DATA_W = 32;
  localparam logic IDLE = 1'b0;
  localparam logic SEND = 1'b1;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/ip_wr_fifo.sv
// ip_wr_fifo: DEPTH-entry FIFO holding IP writes between the pipeline and the output register.
//   clk      rising-edge clock
//   rst      asynchronous active-low reset of pointers and level
//   push     write wr_data at the tail (ignored while full)
//   pop      remove the head (ignored while empty)
//   wr_data  word to push
//   rd_data  current head word
//   level    number of stored words
//   full     level == DEPTH
//   empty    level == 0
module ip_wr_fifo import ip_if_pkg::*; #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int LVL_W  = clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic [LVL_W-1:0]  level,
  output logic              full,
  output logic              empty
);
  localparam int PTR_W = clog2(DEPTH);
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              push_ok, pop_ok;
  assign full    = level_q == LVL_W'(DEPTH);
  assign empty   = level_q == '0;
  assign level   = level_q;
  assign rd_data = mem_q[rd_ptr_q];
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  // DEPTH is a power of two, so pointer wrap is the natural PTR_W-bit rollover
  always_comb begin
    wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop_ok ? rd_ptr_q + 1'b1 : rd_ptr_q;
    level_d  = level_q + LVL_W'(push_ok) - LVL_W'(pop_ok);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end
  // storage needs no reset: only entries below level are ever read out
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wr_data;
  end
endmodule

// File: rtl/ip_write_rx.sv
// ip_write_rx: buffers writeback-stage IP writes and hands them to the IP slave over valid/ready.
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   wb_data      write data from MEM/WB
//   wb_ip_write  push wb_data this cycle
//   wb_stall     FIFO full, pipeline must hold MEM/WB
//   ip_valid     ip_data is valid
//   ip_data      output word, held until accepted
//   ip_ready     IP slave accepts the word
//   fifo_level   words queued, excluding the output register
//   overflow     sticky: a push was attempted while full
module ip_write_rx import ip_if_pkg::*; #(
  parameter int DATA_W = ip_if_pkg::DATA_W,
  parameter int DEPTH  = 4,
  parameter int LVL_W  = clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              wb_ip_write,
  output logic              wb_stall,
  output logic              ip_valid,
  output logic [DATA_W-1:0] ip_data,
  input  logic              ip_ready,
  output logic [LVL_W-1:0]  fifo_level,
  output logic              overflow
);
  logic              state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              ovf_q, ovf_d;
  logic [DATA_W-1:0] head;
  logic              full, empty, pop;
  ip_wr_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .LVL_W(LVL_W)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (wb_ip_write),
    .pop     (pop),
    .wr_data (wb_data),
    .rd_data (head),
    .level   (fifo_level),
    .full    (full),
    .empty   (empty)
  );
  assign wb_stall = full;
  assign ip_valid = state_q == SEND;
  assign ip_data  = data_q;
  assign overflow = ovf_q;
  // the output register is free when idle or when its word is being accepted
  assign pop = ~empty & (state_q == IDLE | ip_ready);
  always_comb begin
    state_d = pop ? SEND : (state_q == SEND && ip_ready) ? IDLE : state_q;
    data_d  = pop ? head : data_q;
    ovf_d   = ovf_q | (wb_ip_write & full);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      ovf_q   <= ovf_d;
    end
  end
endmodule
